// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic inter-stage skid buffer with flush, occupancy and stall statistics
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         stall_cycles,
  input  logic                     clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL      = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;

  // Handshake outputs depend only on registered occupancy, never on the other side's inputs.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[head] : '0;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + OCC_W'(1);
      end else if (pop && !push) begin
        count <= count - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (clr_stats) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cycles != STALL_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
